// File: rtl/fp32_pkg.sv
// Shared binary32 constants and pipeline payload types for the divider back end.
package fp32_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam int MANT_W = 24;
  localparam int EXT_W  = 26;
  localparam int EXP_W  = 10;

  // Normalized quotient held between the normalize and round/pack stages.
  typedef struct packed {
    logic                    sign;
    logic [EXT_W-1:0]        n;
    logic signed [EXP_W-1:0] e1;
    logic                    sticky;
    logic                    nan;
    logic                    inf;
    logic                    zero;
    logic                    zm;
  } norm_t;

  typedef struct packed {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    logic        inexact;
  } res_t;

  function automatic logic [31:0] pack_fp(input logic s, input logic [7:0] e,
                                          input logic [22:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/lead_zero.sv
// 24-bit priority leading-zero counter; combinational, returns 24 for an all-zero input.
module lead_zero
  import fp32_pkg::*;
(
  input  logic [MANT_W-1:0] din,
  output logic [4:0]        cnt
);

  // Ascending scan: the highest set bit is the last to write cnt.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < MANT_W; i++) begin
      if (din[i]) cnt = 5'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_div_normalize.sv
// Divider normalize/round/pack: two register stages, result one edge after s1 loads.
// Both stages advance together; a held, unaccepted result stalls the whole pipe and in_ready.
module fp_div_normalize
  import fp32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [EXT_W-1:0]  in_mant,
  input  logic              in_sticky,
  input  logic              in_nan,
  input  logic              in_inf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_inexact
);

  localparam logic signed [EXP_W:0] E2_MAX = (EXP_W+1)'(EXP_MAX);

  logic        en;
  logic        s1_valid;
  logic        s2_valid;
  norm_t       s1;
  norm_t       s1_d;
  res_t        s2;
  res_t        s2_d;
  logic [4:0]  lz;

  assign en       = !(s2_valid && !out_ready);
  assign in_ready = en;

  lead_zero u_lead_zero (
    .din (in_mant[EXT_W-1:2]),
    .cnt (lz)
  );

  // Stage 1: shift the leading one up to bit 25 and compensate the exponent.
  always_comb begin
    s1_d        = '0;
    s1_d.sign   = in_sign;
    s1_d.n      = in_mant << lz;
    s1_d.e1     = $signed(in_exp - {{(EXP_W-5){1'b0}}, lz});
    s1_d.sticky = in_sticky;
    s1_d.nan    = in_nan;
    s1_d.inf    = in_inf;
    s1_d.zero   = in_zero;
    s1_d.zm     = (lz == 5'd24);
  end

  logic [MANT_W-1:0]       m;
  logic                    g;
  logic                    s;
  logic                    up;
  logic [MANT_W:0]         mr;
  logic [22:0]             frac;
  logic signed [EXP_W:0]   e2;

  // Stage 2: round to nearest even, renormalize on carry-out, then classify.
  always_comb begin
    m    = s1.n[EXT_W-1:2];
    g    = s1.n[1];
    s    = s1.n[0] | s1.sticky;
    up   = g & (s | m[0]);
    mr   = {1'b0, m} + {{MANT_W{1'b0}}, up};
    e2   = {s1.e1[EXP_W-1], s1.e1};
    frac = mr[22:0];
    if (mr[MANT_W]) begin
      frac = mr[23:1];
      e2   = e2 + 11'sd1;
    end

    s2_d = '0;
    if (s1.nan) begin
      s2_d.result = QNAN;
    end else if (s1.inf) begin
      s2_d.result = pack_fp(s1.sign, 8'hFF, 23'd0);
    end else if (s1.zero || s1.zm) begin
      s2_d.result = pack_fp(s1.sign, 8'h00, 23'd0);
    end else if (e2 >= E2_MAX) begin
      s2_d.result  = pack_fp(s1.sign, 8'hFF, 23'd0);
      s2_d.ovf     = 1'b1;
      s2_d.inexact = 1'b1;
    end else if (e2 <= 11'sd0) begin
      s2_d.result  = pack_fp(s1.sign, 8'h00, 23'd0);
      s2_d.unf     = 1'b1;
      s2_d.inexact = 1'b1;
    end else begin
      s2_d.result  = pack_fp(s1.sign, e2[7:0], frac);
      s2_d.inexact = g | s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1       <= '0;
      s2       <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) s1 <= s1_d;
      s2_valid <= s1_valid;
      if (s1_valid) s2 <= s2_d;
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2.result;
  assign out_ovf     = s2.ovf;
  assign out_unf     = s2.unf;
  assign out_inexact = s2.inexact;

endmodule

// File: tb/tb_fp_div_normalize.sv
// Scoreboarded bench for fp_div_normalize: directed literal cases, backpressure, reset, random traffic.
module tb_fp_div_normalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [25:0] in_mant = '0;
  logic        in_sticky = 1'b0;
  logic        in_nan = 1'b0;
  logic        in_inf = 1'b0;
  logic        in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inexact;

  always #5 clk = ~clk;

  fp_div_normalize dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_mant     (in_mant),
    .in_sticky   (in_sticky),
    .in_nan      (in_nan),
    .in_inf      (in_inf),
    .in_zero     (in_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_out = 0;
  int stall_seen = 0;
  int or_mode = 0;
  int bp_start = 0;
  logic        hold_vld = 1'b0;
  logic [34:0] hold_val = '0;
  logic [34:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {result, ovf, unf, inexact} straight from the arithmetic definition.
  function automatic logic [34:0] model(input logic sgn, input logic [9:0] ex,
                                        input logic [25:0] mt, input logic stk,
                                        input logic nan, input logic inf, input logic zero);
    int lz;
    int e;
    int mi;
    int gi;
    int si;
    logic [25:0] n;
    if (nan) return {32'h7FC00000, 3'b000};
    if (inf) return {sgn, 8'hFF, 23'd0, 3'b000};
    lz = 0;
    while (lz < 24 && !mt[25-lz]) lz++;
    if (zero || lz == 24) return {sgn, 31'd0, 3'b000};
    n  = mt << lz;
    e  = $signed(ex);
    e  = e - lz;
    mi = int'(n[25:2]);
    gi = int'(n[1]);
    si = int'(n[0] | stk);
    if (gi == 1 && (si == 1 || mi % 2 == 1)) mi = mi + 1;
    if (mi == (1 << 24)) begin
      mi = mi / 2;
      e  = e + 1;
    end
    if (e >= 255) return {sgn, 8'hFF, 23'd0, 3'b101};
    if (e <= 0) return {sgn, 31'd0, 3'b011};
    return {sgn, e[7:0], mi[22:0], 2'b00, (gi | si) != 0};
  endfunction

  always @(negedge clk) begin
    logic [34:0] dv;
    logic [34:0] ev;
    dv = {out_result, out_ovf, out_unf, out_inexact};
    if (rst) begin
      sb.delete();
      hold_vld = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (!in_ready) stall_seen++;
      if (hold_vld) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", dv, hold_val);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          ev = sb.pop_front();
          chk("result", dv, ev);
          n_out++;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_sign, in_exp, in_mant, in_sticky, in_nan, in_inf, in_zero));
      hold_vld = out_valid && !out_ready;
      hold_val = dv;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !((cyc - bp_start) >= 3 && (cyc - bp_start) <= 6);
      endcase
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic sg, input logic [9:0] ex, input logic [25:0] mt,
                      input logic stk, input logic nan, input logic inf, input logic zero);
    int w;
    in_sign = sg; in_exp = ex; in_mant = mt; in_sticky = stk;
    in_nan = nan; in_inf = inf; in_zero = zero;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic dir(input string nm, input logic sg, input logic [9:0] ex,
                     input logic [25:0] mt, input logic stk, input logic nan,
                     input logic inf, input logic zero, input logic [34:0] lit);
    int edges;
    logic got;
    chk({"model_", nm}, model(sg, ex, mt, stk, nan, inf, zero), lit);
    send(sg, ex, mt, stk, nan, inf, zero);
    edges = 1;
    got = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    chk({"seen_", nm}, got, 1);
    chk({"latency_", nm}, edges, 2);
    chk({"dut_", nm}, {out_result, out_ovf, out_unf, out_inexact}, lit);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk(nm, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int t0;
    logic [25:0] rm;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_flags", {out_ovf, out_unf, out_inexact}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    dir("three",      0, 10'd128, 26'h3000000, 0, 0, 0, 0, {32'h40400000, 3'b000});
    dir("half",       0, 10'd127, 26'h1000000, 0, 0, 0, 0, {32'h3F000000, 3'b000});
    dir("tie_odd",    0, 10'd127, {24'hFFFFFF, 2'b10}, 0, 0, 0, 0, {32'h40000000, 3'b001});
    dir("tie_even",   0, 10'd127, {24'h800000, 2'b10}, 0, 0, 0, 0, {32'h3F800000, 3'b001});
    dir("ovf",        0, 10'd255, 26'h2000000, 0, 0, 0, 0, {32'h7F800000, 3'b101});
    dir("unf",        1, 10'd0,   26'h2000000, 0, 0, 0, 0, {32'h80000000, 3'b011});
    dir("nan_inf",    0, 10'd127, 26'h2000000, 0, 1, 1, 0, {32'h7FC00000, 3'b000});
    dir("inf_neg",    1, 10'd127, 26'h2000000, 0, 0, 1, 0, {32'hFF800000, 3'b000});
    dir("mant_zero",  1, 10'd127, 26'h0000000, 1, 0, 0, 0, {32'h80000000, 3'b000});
    dir("zero_flag",  0, 10'd127, 26'h2345678, 1, 0, 0, 1, {32'h00000000, 3'b000});
    dir("carry_ovf",  0, 10'd254, {24'hFFFFFF, 2'b11}, 0, 0, 0, 0, {32'h7F800000, 3'b101});

    // Backpressure: four back-to-back quotients, out_ready low for relative cycles 3..6.
    @(negedge clk);
    n0 = n_out;
    stall_seen = 0;
    bp_start = cyc + 1;
    or_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      send(0, 10'(120 + i), 26'h2000000 | 26'(i << 3), 0, 0, 0, 0);
    drain("bp_drain");
    chk("bp_stall_seen", stall_seen > 0, 1);
    chk("bp_count", n_out - n0, 4);

    // Full rate with out_ready held high.
    @(negedge clk);
    or_mode = 0;
    @(posedge clk);
    #1;
    n0 = n_out;
    t0 = cyc;
    for (int i = 0; i < 16; i++)
      send(i[0], 10'(100 + i), 26'($urandom) | 26'h2000000, 1'($urandom), 0, 0, 0);
    chk("tput_cycles", cyc - t0, 16);
    drain("tput_drain");
    chk("tput_count", n_out - n0, 16);

    // Reset with both stages occupied.
    for (int i = 0; i < 3; i++)
      send(0, 10'd130, 26'($urandom) | 26'h1000000, 0, 0, 0, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_mant = 26'h3FFFFFF;
    @(negedge clk);
    chk("midrst_pre_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    repeat (5) @(negedge clk);
    chk("midrst_no_stale", out_valid, 0);
    @(posedge clk);
    #1;

    // Random traffic with random downstream stalls.
    @(negedge clk);
    or_mode = 1;
    @(posedge clk);
    #1;
    n0 = n_out;
    for (int i = 0; i < 300; i++) begin
      logic [9:0] ex;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rm = 26'($urandom) >> $urandom_range(0, 26);
      if ($urandom_range(0, 3) == 0) ex = 10'($urandom_range(245, 262));
      else if ($urandom_range(0, 3) == 0) ex = 10'($urandom_range(0, 30) - 10);
      else ex = 10'($urandom_range(0, 600) - 300);
      send(1'($urandom), ex, rm, 1'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    or_mode = 0;
    drain("rand_drain");
    chk("rand_count", n_out - n0, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
